// File: rtl/soc_gpio.sv
// soc_gpio: memory-mapped GPIO with set/clear/toggle aliases,
// synchronised inputs and per-bit rising-edge interrupts.
module soc_gpio #(
  parameter int NUM_PORTS = 2,
  parameter int PORT_WIDTH = 8,
  parameter logic [PORT_WIDTH-1:0] OUT_RESET = '0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            sel,
  input  logic [7:0]                      addr,
  input  logic [31:0]                     wdata,
  input  logic [3:0]                      wmask,
  input  logic                            rstrb,
  output logic [31:0]                     rdata,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_in,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_out,
  output logic                            irq
);

  localparam int W = NUM_PORTS * PORT_WIDTH;
  localparam int PW = PORT_WIDTH;

  typedef enum logic [2:0] {
    R_OUT, R_SET, R_CLR, R_TGL,
    R_IN, R_EN, R_STAT, R_RSV
  } reg_e;

  logic [W-1:0]  r_out, r_en, r_stat;
  logic [W-1:0]  r_s1, r_s2, r_d;
  logic [31:0]   r_rdata;

  logic [4:0]    w_port;
  reg_e          w_reg;
  logic          w_wr, w_rd;
  logic [PW-1:0] w_bmask, w_data, w_rval;
  logic [W-1:0]  w_edge;
  logic [W-1:0]  w_out_nxt, w_en_nxt, w_stat_nxt;
  logic          w_unused;

  assign w_port = addr[7:3];
  assign w_reg = reg_e'(addr[2:0]);
  assign w_wr = sel & (|wmask);
  assign w_rd = sel & rstrb;
  assign w_edge = r_s2 & ~r_d;
  assign w_unused = ^wdata;

  always_comb begin
    w_bmask = '0;
    for (int i = 0; i < PW; i++)
      w_bmask[i] = wmask[i>>3];
  end

  assign w_data = wdata[PW-1:0] & w_bmask;

  // Out-of-range port indices match no port: read 0, writes dropped.
  always_comb begin
    w_out_nxt = r_out;
    w_en_nxt = r_en;
    w_stat_nxt = r_stat | (w_edge & r_en);
    w_rval = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_port == 5'(p)) begin
        case (w_reg)
          R_OUT, R_SET,
          R_CLR, R_TGL: w_rval = r_out[p*PW +: PW];
          R_IN:         w_rval = r_s2[p*PW +: PW];
          R_EN:         w_rval = r_en[p*PW +: PW];
          R_STAT:       w_rval = r_stat[p*PW +: PW];
          default:      w_rval = '0;
        endcase
        if (w_wr) begin
          case (w_reg)
            R_OUT: w_out_nxt[p*PW +: PW] =
              (r_out[p*PW +: PW] & ~w_bmask) | w_data;
            R_SET: w_out_nxt[p*PW +: PW] =
              r_out[p*PW +: PW] | w_data;
            R_CLR: w_out_nxt[p*PW +: PW] =
              r_out[p*PW +: PW] & ~w_data;
            R_TGL: w_out_nxt[p*PW +: PW] =
              r_out[p*PW +: PW] ^ w_data;
            R_EN: w_en_nxt[p*PW +: PW] =
              (r_en[p*PW +: PW] & ~w_bmask) | w_data;
            // A new edge in the same cycle beats the W1C.
            R_STAT: w_stat_nxt[p*PW +: PW] =
              (r_stat[p*PW +: PW] & ~w_data)
              | (w_edge[p*PW +: PW] & r_en[p*PW +: PW]);
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= {NUM_PORTS{OUT_RESET}};
      r_en <= '0;
      r_stat <= '0;
      r_s1 <= '0;
      r_s2 <= '0;
      r_d <= '0;
      r_rdata <= '0;
    end else begin
      r_s1 <= gpio_in;
      r_s2 <= r_s1;
      r_d <= r_s2;
      r_out <= w_out_nxt;
      r_en <= w_en_nxt;
      r_stat <= w_stat_nxt;
      if (w_rd)
        r_rdata <= 32'(w_rval);
    end
  end

  assign gpio_out = r_out;
  assign rdata = r_rdata;
  assign irq = |(r_stat & r_en);

endmodule

// File: tb/tb_soc_gpio.sv
// tb_soc_gpio: table-driven register checks plus hand-written
// sequences for the interrupt and reset corner cases.
module tb_soc_gpio;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        rstrb;
  logic [31:0] rdata;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic        irq;

  int n_pass = 0;
  int n_total = 0;

  soc_gpio #(
    .NUM_PORTS(2),
    .PORT_WIDTH(8),
    .OUT_RESET(8'hA5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sel(sel),
    .addr(addr),
    .wdata(wdata),
    .wmask(wmask),
    .rstrb(rstrb),
    .rdata(rdata),
    .gpio_in(gpio_in),
    .gpio_out(gpio_out),
    .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [4:0]  port;
    logic [2:0]  rg;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tv[15];

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic bus_write(input logic [4:0] port,
                           input logic [2:0] rg,
                           input logic [31:0] data,
                           input logic [3:0] mask);
    @(negedge clk);
    sel = 1'b1;
    addr = {port, rg};
    wdata = data;
    wmask = mask;
    @(negedge clk);
    sel = 1'b0;
    wmask = 4'b0;
  endtask

  task automatic bus_read(input logic [4:0] port,
                          input logic [2:0] rg,
                          output logic [31:0] data);
    @(negedge clk);
    sel = 1'b1;
    rstrb = 1'b1;
    addr = {port, rg};
    @(negedge clk);
    sel = 1'b0;
    rstrb = 1'b0;
    data = rdata;
  endtask

  initial begin
    logic [31:0] rv;

    tv[0]  = '{1'b1, 5'd1, 3'd5, 32'h0,  4'h0, 32'h00,   "rst_en1"};
    tv[1]  = '{1'b0, 5'd0, 3'd0, 32'h0F, 4'h1, 32'hA50F, "out_wr"};
    tv[2]  = '{1'b0, 5'd0, 3'd1, 32'hF0, 4'h1, 32'hA5FF, "set"};
    tv[3]  = '{1'b0, 5'd0, 3'd2, 32'h03, 4'h1, 32'hA5FC, "clr"};
    tv[4]  = '{1'b0, 5'd0, 3'd3, 32'hFF, 4'h1, 32'hA503, "tgl"};
    tv[5]  = '{1'b0, 5'd1, 3'd0, 32'h3C, 4'h2, 32'hA503, "lane_off"};
    tv[6]  = '{1'b0, 5'd3, 3'd0, 32'h55, 4'h1, 32'hA503, "port_oor"};
    tv[7]  = '{1'b0, 5'd1, 3'd3, 32'h0F, 4'h1, 32'hAA03, "tgl_p1"};
    tv[8]  = '{1'b0, 5'd0, 3'd7, 32'hFF, 4'hF, 32'hAA03, "rsv_wr"};
    tv[9]  = '{1'b1, 5'd0, 3'd0, 32'h0,  4'h0, 32'h03,   "rd_out0"};
    tv[10] = '{1'b1, 5'd0, 3'd1, 32'h0,  4'h0, 32'h03,   "rd_set"};
    tv[11] = '{1'b1, 5'd1, 3'd7, 32'h0,  4'h0, 32'h00,   "rd_rsv"};
    tv[12] = '{1'b1, 5'd3, 3'd0, 32'h0,  4'h0, 32'h00,   "rd_oor"};
    tv[13] = '{1'b1, 5'd1, 3'd0, 32'h0,  4'h0, 32'hAA,   "rd_out1"};
    tv[14] = '{1'b1, 5'd0, 3'd4, 32'h0,  4'h0, 32'h00,   "rd_in0"};

    reset = 1'b1;
    sel = 1'b0;
    addr = '0;
    wdata = '0;
    wmask = '0;
    rstrb = 1'b0;
    gpio_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_out", 32'(gpio_out), 32'hA5A5);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rdata", rdata, 32'h0);

    for (int i = 0; i < 15; i++) begin
      if (tv[i].rd) begin
        bus_read(tv[i].port, tv[i].rg, rv);
        check(tv[i].name, rv, tv[i].exp);
      end else begin
        bus_write(tv[i].port, tv[i].rg, tv[i].data, tv[i].mask);
        check(tv[i].name, 32'(gpio_out), tv[i].exp);
      end
    end

    // Rising edge on bit 8 with port1 EN bit 0 set
    bus_write(5'd1, 3'd5, 32'h01, 4'h1);
    @(negedge clk);
    gpio_in[8] = 1'b1;
    @(posedge clk); #1;
    check("irq_e0", 32'(irq), 32'h0);
    @(posedge clk); #1;
    check("irq_e1", 32'(irq), 32'h0);
    @(posedge clk); #1;
    check("irq_e2", 32'(irq), 32'h1);
    bus_read(5'd1, 3'd6, rv);
    check("stat1", rv, 32'h01);
    bus_read(5'd1, 3'd4, rv);
    check("in1", rv, 32'h01);
    bus_write(5'd1, 3'd6, 32'h01, 4'h1);
    check("w1c_irq", 32'(irq), 32'h0);
    bus_read(5'd1, 3'd6, rv);
    check("w1c_stat", rv, 32'h00);

    // Edge while disabled is discarded
    @(negedge clk);
    gpio_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    bus_write(5'd0, 3'd5, 32'h01, 4'h1);
    check("dis_irq", 32'(irq), 32'h0);
    bus_read(5'd0, 3'd6, rv);
    check("dis_stat", rv, 32'h00);

    // Edge on bit 9 coinciding with W1C of the same bit
    bus_write(5'd1, 3'd5, 32'h03, 4'h1);
    @(negedge clk);
    gpio_in[9] = 1'b1;
    repeat (4) @(negedge clk);
    check("b9_irq", 32'(irq), 32'h1);
    gpio_in[9] = 1'b0;
    repeat (4) @(negedge clk);
    gpio_in[9] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    bus_write(5'd1, 3'd6, 32'h02, 4'h1);
    check("race_irq", 32'(irq), 32'h1);
    bus_read(5'd1, 3'd6, rv);
    check("race_stat", rv, 32'h02);

    // Clearing EN keeps STAT but drops irq
    bus_write(5'd1, 3'd5, 32'h00, 4'h1);
    check("en0_irq", 32'(irq), 32'h0);
    bus_read(5'd1, 3'd6, rv);
    check("en0_stat", rv, 32'h02);

    // Write with sel low is ignored
    @(negedge clk);
    addr = {5'd0, 3'd0};
    wdata = 32'h77;
    wmask = 4'h1;
    @(negedge clk);
    wmask = 4'h0;
    check("sel_low", 32'(gpio_out), 32'hAA03);

    // Reset during a write aborts it
    @(negedge clk);
    sel = 1'b1;
    addr = {5'd0, 3'd0};
    wdata = 32'hFF;
    wmask = 4'h1;
    reset = 1'b1;
    @(negedge clk);
    sel = 1'b0;
    wmask = 4'h0;
    reset = 1'b0;
    check("mid_rst", 32'(gpio_out), 32'hA5A5);
    bus_read(5'd1, 3'd5, rv);
    check("mid_rst_en", rv, 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
